// File: rtl/alarm_ctrl.sv
// Alarm sequencer: detects the alarm-time match, arms/disarms, rings with a
// 1 s on / 1 s off beep, handles bounded snooze and auto-silences on timeout.
module alarm_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic [19:0] curr_time,
  input  logic [19:0] alarm_time,
  input  logic        arm_btn,
  input  logic        snooze_btn,
  input  logic        stop_btn,
  output logic        armed,
  output logic        ringing,
  output logic        buzzer,
  output logic        snoozing,
  output logic [2:0]  snooze_left
);

  localparam logic [7:0] RING_LAST  = 8'(RING_SECS - 1);
  localparam logic [9:0] SNZ_LAST   = 10'(SNOOZE_MIN * 60 - 1);
  localparam logic [2:0] SNZ_RELOAD = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] ring_cnt;
  logic [9:0] snz_cnt;
  logic       beep_phase;
  logic       match_q;
  logic       match_prev;
  logic       trigger;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // Trigger fires once on the rising edge of the registered equality,
  // so holding the time at the match value never retriggers.
  assign trigger = match_q & ~match_prev;

  // Match detector: registered equality plus its one-cycle delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q    <= 1'b0;
      match_prev <= 1'b0;
    end else begin
      match_q    <= (curr_time == alarm_time);
      match_prev <= match_q;
    end
  end

  // Alarm state machine with ring/snooze counters; buttons outrank ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DISARMED;
      ring_cnt    <= 8'd0;
      snz_cnt     <= 10'd0;
      beep_phase  <= 1'b0;
      snooze_left <= SNZ_RELOAD;
    end else begin
      case (state)
        DISARMED: begin
          if (arm_btn) state <= ARMED;
        end
        ARMED: begin
          if (arm_btn) begin
            state <= DISARMED;
          end else if (trigger) begin
            state       <= RINGING;
            snooze_left <= SNZ_RELOAD;
            ring_cnt    <= 8'd0;
            beep_phase  <= 1'b1;
          end
        end
        RINGING: begin
          if (arm_btn) begin
            state <= DISARMED;
          end else if (stop_btn) begin
            state <= ARMED;
          end else if (snooze_btn && (snooze_left != 3'd0)) begin
            state       <= SNOOZE;
            snooze_left <= snooze_left - 3'd1;
            snz_cnt     <= 10'd0;
          end else if (sec_tick) begin
            ring_cnt   <= sat_inc8(ring_cnt);
            beep_phase <= ~beep_phase;
            if (ring_cnt == RING_LAST) state <= ARMED;
          end
        end
        SNOOZE: begin
          if (arm_btn) begin
            state <= DISARMED;
          end else if (stop_btn) begin
            state <= ARMED;
          end else if (sec_tick) begin
            if (snz_cnt == SNZ_LAST) begin
              state      <= RINGING;
              ring_cnt   <= 8'd0;
              beep_phase <= 1'b1;
            end else begin
              snz_cnt <= sat_inc10(snz_cnt);
            end
          end
        end
        default: state <= DISARMED;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign armed    = (state != DISARMED);
  assign ringing  = (state == RINGING);
  assign snoozing = (state == SNOOZE);
  assign buzzer   = ringing & beep_phase;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: vector table for the first ring, then
// hand sequences for timeout, snooze exhaustion, button conflicts and reset.
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sec_tick;
  logic [19:0] curr_time;
  logic [19:0] alarm_time;
  logic        arm_btn;
  logic        snooze_btn;
  logic        stop_btn;
  logic        armed;
  logic        ringing;
  logic        buzzer;
  logic        snoozing;
  logic [2:0]  snooze_left;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_ctrl #(.RING_SECS(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .curr_time(curr_time), .alarm_time(alarm_time),
    .arm_btn(arm_btn), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .armed(armed), .ringing(ringing), .buzzer(buzzer),
    .snoozing(snoozing), .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] ct;
    logic        arm;
    logic        snz;
    logic        stop;
    logic        tick;
    logic [6:0]  exp;   // {armed, ringing, buzzer, snoozing, snooze_left}
  } vec_t;

  vec_t vecs[8];

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {armed, ringing, buzzer, snoozing, snooze_left};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {arm,ring,buz,snz,left}=%b required %b", name, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
      step();
    end
  endtask

  task automatic pulse(input logic a, input logic sn, input logic st);
    arm_btn = a; snooze_btn = sn; stop_btn = st;
    step();
    arm_btn = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
  endtask

  // Move away from the alarm time and back, producing a fresh trigger.
  task automatic retrigger();
    curr_time = bcd(7, 30, 1);
    step();
    step();
    curr_time = bcd(7, 30, 0);
    step();
    step();
  endtask

  initial begin
    reset      = 1'b1;
    sec_tick   = 1'b0;
    arm_btn    = 1'b0;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    alarm_time = bcd(7, 30, 0);
    curr_time  = bcd(7, 29, 0);

    vecs[0] = '{bcd(7, 29, 58), 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000011};
    vecs[1] = '{bcd(7, 29, 59), 1'b0, 1'b0, 1'b0, 1'b1, 7'b1000011};
    vecs[2] = '{bcd(7, 30, 0),  1'b0, 1'b0, 1'b0, 1'b1, 7'b1000011};
    vecs[3] = '{bcd(7, 30, 0),  1'b0, 1'b0, 1'b0, 1'b0, 7'b1110011};
    vecs[4] = '{bcd(7, 30, 0),  1'b0, 1'b0, 1'b0, 1'b1, 7'b1100011};
    vecs[5] = '{bcd(7, 30, 0),  1'b0, 1'b0, 1'b0, 1'b1, 7'b1110011};
    vecs[6] = '{bcd(7, 30, 0),  1'b0, 1'b0, 1'b0, 1'b0, 7'b1110011};
    vecs[7] = '{bcd(7, 30, 0),  1'b0, 1'b0, 1'b0, 1'b1, 7'b1100011};

    step();
    step();
    check("in_reset", 7'b0000011);
    reset = 1'b0;
    step();
    check("after_reset", 7'b0000011);

    // First ring: arm, sweep to the match, beep toggling on ticks.
    for (int i = 0; i < 8; i++) begin
      curr_time  = vecs[i].ct;
      arm_btn    = vecs[i].arm;
      snooze_btn = vecs[i].snz;
      stop_btn   = vecs[i].stop;
      sec_tick   = vecs[i].tick;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    arm_btn = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0; sec_tick = 1'b0;

    // Timeout: three ticks already counted, 56 more leaves it ringing.
    ticks(56);
    check("ring_before_timeout", 7'b1100011);
    ticks(1);
    check("ring_timeout", 7'b1000011);
    for (int i = 0; i < 4; i++) step();
    check("no_retrigger_on_hold", 7'b1000011);

    // Snooze three times, then the fourth request is ignored.
    retrigger();
    check("ring_for_snooze", 7'b1110011);
    for (int k = 1; k <= 3; k++) begin
      pulse(1'b0, 1'b1, 1'b0);
      check($sformatf("snooze%0d_enter", k), {4'b1001, 3'(3 - k)});
      ticks(299);
      check($sformatf("snooze%0d_hold", k), {4'b1001, 3'(3 - k)});
      ticks(1);
      check($sformatf("snooze%0d_wake", k), {4'b1110, 3'(3 - k)});
    end
    pulse(1'b0, 1'b1, 1'b0);
    check("snooze4_ignored", 7'b1110000);
    pulse(1'b0, 1'b0, 1'b1);
    check("stop_keeps_left", 7'b1000000);
    retrigger();
    check("trigger_reloads_left", 7'b1110011);

    // Stop and snooze together: stop wins.
    pulse(1'b0, 1'b1, 1'b1);
    check("stop_beats_snooze", 7'b1000011);

    // Disarm while snoozing; a later match must not ring.
    retrigger();
    pulse(1'b0, 1'b1, 1'b0);
    check("snooze_before_disarm", 7'b1001010);
    pulse(1'b1, 1'b0, 1'b0);
    check("disarm_from_snooze", 7'b0000010);
    retrigger();
    step();
    check("disarmed_ignores_match", 7'b0000010);

    // Asynchronous reset in the middle of a ring.
    pulse(1'b1, 1'b0, 1'b0);
    retrigger();
    pulse(1'b0, 1'b1, 1'b0);
    ticks(300);
    check("ring_before_reset", 7'b1110010);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_ring", 7'b0000011);
    step();
    step();
    reset = 1'b0;
    step();
    check("post_reset_disarmed", 7'b0000011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
